led_shift_chain: RTL
====================

LED_SHIFT_CHAIN -- requirements
Module: led_shift_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of chain stages / LED outputs (legal range 2..32).
REQ-002 The block SHALL have parameter DIV, default 125000000, giving clk cycles per step tick (legal range 1..2^32-1); this default yields 1 Hz at 125 MHz.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth on din (legal range 2..4).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock (SYSCLK_125MHZ domain).
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port din, input, 1 bit: asynchronous serial input (push button).
REQ-007 The block SHALL have port mode, input, 2 bits: 00 shift-left, 01 shift-right, 10 rotate-left, 11 broadcast.
REQ-008 The block SHALL have port hold, input, 1 bit, synchronous: when high, the chain does not step.
REQ-009 The block SHALL have port load, input, 1 bit, synchronous: parallel load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: parallel load data.
REQ-011 The block SHALL have port leds, output, WIDTH bits, registered: chain state (leds[0] is the head stage).
REQ-012 The block SHALL have port tick, output, 1 bit, registered: one-cycle step strobe.

Function
REQ-013 The block SHALL pass din through SYNC_STAGES flops; only the last stage (din_s) is used internally.
REQ-014 The divider SHALL count 0..DIV-1 and wrap to 0, raising an internal strobe in the cycle count==DIV-1; for DIV=1 the strobe SHALL be high every cycle.
REQ-015 The registered tick output SHALL equal the internal strobe delayed one cycle, and chain steps SHALL occur on the same edge at which tick rises.
REQ-016 In mode 00, each step SHALL shift leds left by one, with leds[0]<=din_s and leds[WIDTH-1] discarded.
REQ-017 In mode 01, each step SHALL shift leds right by one, with leds[WIDTH-1]<=din_s and leds[0] discarded.
REQ-018 In mode 10, each step SHALL rotate leds left (leds[0]<=leds[WIDTH-1]) and SHALL ignore din_s.
REQ-019 In mode 11, each step SHALL load din_s into every stage simultaneously (all-ones or all-zeros).
REQ-020 mode SHALL be sampled on the stepping edge only; a change between steps SHALL take effect at the next step.
REQ-021 Priority SHALL be load > hold > step.
REQ-022 When load is high, leds<=load_val on that edge, the divider SHALL clear to 0, and any coincident step SHALL be discarded.
REQ-023 When hold is high, leds SHALL be frozen, while the divider and tick SHALL keep running; steps falling during hold SHALL be lost, not queued.
REQ-024 leds SHALL change only on a step or load edge, and SHALL be glitch-free registered outputs.
REQ-025 Latency from a din edge to its first appearance in leds SHALL be SYNC_STAGES cycles plus the wait to the next step.

Reset
REQ-026 Assertion of rst_n=0 SHALL asynchronously clear leds, tick, the divider count and all synchroniser flops to 0.
REQ-027 After rst_n deasserts, the first strobe SHALL occur at count==DIV-1, i.e. DIV cycles after the first active edge.
REQ-028 A reset mid-count or mid-hold SHALL discard all progress, with no residual step.

Verification
REQ-029 Shift-left: WIDTH=8, DIV=4, din=1 held, mode=00 -> tick every 4 cycles; leds = 01, 03, 07 ... FF after 8 steps.
REQ-030 Rotate: load load_val=8'h81, mode=10 -> steps give 03, 06, 0C; 8 steps return 81; divider restarts from 0 at the load.
REQ-031 Broadcast and hold: mode=11, din=1 -> FF on the next step; hold=1 across 3 ticks -> leds stays FF and tick keeps pulsing; din=0, hold=0 -> 00 on the next step.
REQ-032 Priority: load and hold asserted in the same cycle as a step -> leds=load_val, no step, and the next tick DIV cycles later.
REQ-033 Reset mid-operation: rst_n pulsed low while leds=5A with count at 2 -> leds=00 and tick=0 immediately; first tick arrives DIV cycles after release.
REQ-034 DIV=1, mode=01, din toggling -> step every cycle; leds[7] follows din delayed by SYNC_STAGES+1 cycles.

Source files
------------

// File: rtl/led_shift_chain.sv
// LED shift chain: a WIDTH-stage register fed from a synchronised push-button
// input, stepping once per DIV clock cycles in one of four modes
// (shift-left, shift-right, rotate-left, broadcast). A parallel load overrides
// everything and restarts the step divider. hold freezes the LEDs only; the
// divider and tick keep running.
module led_shift_chain #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIV         = 125000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [1:0]       mode,
  input  logic             hold,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             tick
);

  localparam logic [31:0] CNT_LAST = 32'(DIV - 1);

  localparam logic [1:0] MODE_SHL = 2'b00;
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_BC  = 2'b11;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]       leds_q, leds_d;
  logic                   tick_q, tick_d;
  logic                   din_s;
  logic                   strobe;

  assign din_s  = sync_q[SYNC_STAGES-1];
  assign strobe = (cnt_q == CNT_LAST);

  // Synchroniser: din enters at bit 0 and leaves as din_s at the top bit.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // Step divider: wraps at DIV-1 and restarts from zero on a parallel load.
  // With DIV=1 the count stays at 0, so the strobe is high every cycle.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (load || strobe) begin
      cnt_d = '0;
    end
  end

  // tick is the strobe delayed one cycle, so a step and the rising tick share
  // an edge. A step coinciding with a load is discarded, but tick still
  // reflects the strobe that occurred.
  always_comb begin
    tick_d = strobe;
  end

  // Chain update, priority load > hold > step. mode is only looked at here,
  // so a mode change between steps takes effect on the next step.
  always_comb begin
    leds_d = leds_q;
    if (load) begin
      leds_d = load_val;
    end else if (strobe && !hold) begin
      case (mode)
        MODE_SHL: leds_d = {leds_q[WIDTH-2:0], din_s};
        MODE_SHR: leds_d = {din_s, leds_q[WIDTH-1:1]};
        MODE_ROL: leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
        MODE_BC:  leds_d = {WIDTH{din_s}};
        default:  leds_d = leds_q;
      endcase
    end
  end

  // State registers; reset clears everything, including synchroniser flops,
  // so no progress survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      leds_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      leds_q <= leds_d;
      tick_q <= tick_d;
    end
  end

  assign leds = leds_q;
  assign tick = tick_q;

endmodule
